// File: rtl/music_sequencer.sv
// Background-music sequencer: steps a per-song note table at a fixed beat rate and emits a
// volume-scaled square wave. Define BGM_HARMONY_EN for a right-channel tone one octave lower.
module music_sequencer #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BEAT_HZ  = 8,
    parameter int SONG_LEN = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         state,
    input  logic               vol_up,
    input  logic               vol_down,
    input  logic               mute,
    output logic signed [15:0] audio_in_left,
    output logic signed [15:0] audio_in_right,
    output logic [2:0]         volume,
    output logic [5:0]         note_idx
);

    localparam int BEAT_DIV = CLK_FREQ / BEAT_HZ;
    localparam int BEAT_W   = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEAT_DIV - 1);
    localparam logic [5:0]        IDX_LAST  = 6'(SONG_LEN - 1);

    localparam logic [19:0] HP_C4 = 20'(CLK_FREQ / (2 * 262));
    localparam logic [19:0] HP_D4 = 20'(CLK_FREQ / (2 * 294));
    localparam logic [19:0] HP_E4 = 20'(CLK_FREQ / (2 * 330));
    localparam logic [19:0] HP_F4 = 20'(CLK_FREQ / (2 * 349));
    localparam logic [19:0] HP_G4 = 20'(CLK_FREQ / (2 * 392));
    localparam logic [19:0] HP_A4 = 20'(CLK_FREQ / (2 * 440));
    localparam logic [19:0] HP_B4 = 20'(CLK_FREQ / (2 * 494));
    localparam logic [19:0] HP_C5 = 20'(CLK_FREQ / (2 * 523));
    localparam logic [19:0] HP_D5 = 20'(CLK_FREQ / (2 * 587));
    localparam logic [19:0] HP_E5 = 20'(CLK_FREQ / (2 * 659));
    localparam logic [19:0] HP_G5 = 20'(CLK_FREQ / (2 * 784));

    // Song tables read left to right: the leftmost hex digit is note 0.
    localparam logic [255:0] SONG0 =
        256'h6688_6655_4433_2211_6688_6655_4433_2200_5577_AA99_8877_6655_6688_6655_3322_1100;
    localparam logic [255:0] SONG1 =
        256'h1133_5588_8855_3311_2244_6699_9966_4422_1133_5588_BBAA_9988_7766_5544_3322_1100;
    localparam logic [255:0] SONG2 =
        256'hCA0B_0A09_0807_0605_0403_0201_0102_0304_0506_0708_090A_0B00_5500_5500_6600_7700;

    logic [3:0]         state_q;
    logic [BEAT_W-1:0]  beatCnt_q, beatCnt_d;
    logic [5:0]         noteIdx_q, noteIdx_d;
    logic [19:0]        toneCnt_q, toneCnt_d;
    logic               phase_q, phase_d;
    logic [2:0]         volume_q, volume_d;
    logic signed [15:0] left_q, left_d;

    logic               stateChg, beatTick, noteChg, isRest, silent;
    logic [7:0]         romBase;
    logic [3:0]         noteCode;
    logic [19:0]        halfPer;
    logic signed [15:0] amp;

    assign romBase = {~noteIdx_q, 2'b00};

    always_comb begin
        noteCode = 4'd0;
        case (state_q[1:0])
            2'd0:    noteCode = SONG0[romBase +: 4];
            2'd1:    noteCode = SONG1[romBase +: 4];
            2'd2:    noteCode = SONG2[romBase +: 4];
            default: noteCode = 4'd0;
        endcase
    end

    always_comb begin
        halfPer = 20'd1;
        case (noteCode)
            4'd1:    halfPer = HP_C4;
            4'd2:    halfPer = HP_D4;
            4'd3:    halfPer = HP_E4;
            4'd4:    halfPer = HP_F4;
            4'd5:    halfPer = HP_G4;
            4'd6:    halfPer = HP_A4;
            4'd7:    halfPer = HP_B4;
            4'd8:    halfPer = HP_C5;
            4'd9:    halfPer = HP_D5;
            4'd10:   halfPer = HP_E5;
            4'd11:   halfPer = HP_G5;
            default: halfPer = 20'd1;
        endcase
    end

    assign isRest = (noteCode == 4'd0) || (noteCode >= 4'd12);

    // A state change outranks a simultaneous beat tick.
    always_comb begin
        stateChg  = (state != state_q);
        beatTick  = (beatCnt_q == BEAT_LAST);
        beatCnt_d = beatCnt_q + BEAT_W'(1);
        noteIdx_d = noteIdx_q;
        if (stateChg) begin
            beatCnt_d = '0;
            noteIdx_d = '0;
        end else if (beatTick) begin
            beatCnt_d = '0;
            noteIdx_d = (noteIdx_q == IDX_LAST) ? 6'd0 : noteIdx_q + 6'd1;
        end
        noteChg = stateChg | beatTick;
    end

    always_comb begin
        toneCnt_d = toneCnt_q + 20'd1;
        phase_d   = phase_q;
        if (noteChg || isRest) begin
            toneCnt_d = '0;
            phase_d   = 1'b0;
        end else if (toneCnt_q == halfPer - 20'd1) begin
            toneCnt_d = '0;
            phase_d   = ~phase_q;
        end
    end

    always_comb begin
        volume_d = volume_q;
        if (vol_up && !vol_down && volume_q != 3'd7) begin
            volume_d = volume_q + 3'd1;
        end else if (vol_down && !vol_up && volume_q != 3'd0) begin
            volume_d = volume_q - 3'd1;
        end
    end

    assign amp    = {2'b00, volume_q, 11'd0};
    assign silent = isRest || mute || (volume_q == 3'd0);

    always_comb begin
        left_d = '0;
        if (!silent) begin
            left_d = phase_q ? amp : -amp;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= state;
            beatCnt_q <= '0;
            noteIdx_q <= '0;
            toneCnt_q <= '0;
            phase_q   <= 1'b0;
            volume_q  <= 3'd4;
            left_q    <= '0;
        end else begin
            state_q   <= state;
            beatCnt_q <= beatCnt_d;
            noteIdx_q <= noteIdx_d;
            toneCnt_q <= toneCnt_d;
            phase_q   <= phase_d;
            volume_q  <= volume_d;
            left_q    <= left_d;
        end
    end

`ifdef BGM_HARMONY_EN
    logic [19:0]        toneCnt2_q, toneCnt2_d;
    logic               phase2_q, phase2_d;
    logic signed [15:0] right_q, right_d;
    logic [19:0]        halfPer2;

    // Doubling the half period drops the right channel by one octave.
    assign halfPer2 = {halfPer[18:0], 1'b0};

    always_comb begin
        toneCnt2_d = toneCnt2_q + 20'd1;
        phase2_d   = phase2_q;
        if (noteChg || isRest) begin
            toneCnt2_d = '0;
            phase2_d   = 1'b0;
        end else if (toneCnt2_q == halfPer2 - 20'd1) begin
            toneCnt2_d = '0;
            phase2_d   = ~phase2_q;
        end
    end

    always_comb begin
        right_d = '0;
        if (!silent) begin
            right_d = phase2_q ? amp : -amp;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            toneCnt2_q <= '0;
            phase2_q   <= 1'b0;
            right_q    <= '0;
        end else begin
            toneCnt2_q <= toneCnt2_d;
            phase2_q   <= phase2_d;
            right_q    <= right_d;
        end
    end

    assign audio_in_right = right_q;
`else
    assign audio_in_right = left_q;
`endif

    assign audio_in_left = left_q;
    assign volume        = volume_q;
    assign note_idx      = noteIdx_q;

endmodule

// File: tb/tb_music_sequencer.sv
// Scoreboard bench for music_sequencer: a time-based reference model predicts every output
// sample, volume and note index; a monitor compares them on the falling clock edge.
module tb_music_sequencer;

    localparam int TB_CLK   = 100_000;
    localparam int TB_BEAT  = 80;
    localparam int TB_LEN   = 16;
    localparam int BEAT_DIV = TB_CLK / TB_BEAT;

    typedef struct {
        logic signed [15:0] left;
        logic signed [15:0] right;
        logic [2:0]         vol;
        logic [5:0]         idx;
    } expT;

    logic               clk = 1'b0;
    logic               rst;
    logic [3:0]         stateIn;
    logic               volUp;
    logic               volDown;
    logic               muteIn;
    logic signed [15:0] audioL;
    logic signed [15:0] audioR;
    logic [2:0]         volOut;
    logic [5:0]         idxOut;

    music_sequencer #(
        .CLK_FREQ(TB_CLK),
        .BEAT_HZ (TB_BEAT),
        .SONG_LEN(TB_LEN)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .state         (stateIn),
        .vol_up        (volUp),
        .vol_down      (volDown),
        .mute          (muteIn),
        .audio_in_left (audioL),
        .audio_in_right(audioR),
        .volume        (volOut),
        .note_idx      (idxOut)
    );

    always #5 clk = ~clk;

    expT   sbQ[$];
    int    vectors     = 0;
    int    miscompares = 0;
    int    cycle       = 0;
    int    songTab[4][64];
    int    freqTab[16] = '{0, 262, 294, 330, 349, 392, 440, 494, 523, 587, 659, 784, 0, 0, 0, 0};
    string songTxt[3]  = '{
        "6688_6655_4433_2211_6688_6655_4433_2200_5577_AA99_8877_6655_6688_6655_3322_1100",
        "1133_5588_8855_3311_2244_6699_9966_4422_1133_5588_BBAA_9988_7766_5544_3322_1100",
        "CA0B_0A09_0807_0605_0403_0201_0102_0304_0506_0708_090A_0B00_5500_5500_6600_7700"
    };

    // Model: note age counts clocks since the note began; the square phase follows from it.
    int         mVol  = 4;
    int         mIdx  = 0;
    int         mBeat = 0;
    int         mAge  = 0;
    int         mPrev = 0;
    logic [3:0] curState = 4'd0;
    logic       curMute  = 1'b0;

    task automatic loadSongs();
        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < 64; i++) songTab[s][i] = 0;
        end
        for (int s = 0; s < 3; s++) begin
            int n = 0;
            for (int i = 0; i < songTxt[s].len(); i++) begin
                byte c = songTxt[s][i];
                if (c >= 8'h30 && c <= 8'h39) begin
                    songTab[s][n] = int'(c) - 48;
                    n++;
                end else if (c >= 8'h41 && c <= 8'h46) begin
                    songTab[s][n] = int'(c) - 65 + 10;
                    n++;
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [3:0] s, input logic up,
                                 input logic dn, input logic mu);
        expT e;
        int  code;
        int  hp;
        int  amp;
        rst     = r;
        stateIn = s;
        volUp   = up;
        volDown = dn;
        muteIn  = mu;
        code    = songTab[mPrev % 4][mIdx];
        e.left  = '0;
        e.right = '0;
        if (!r && freqTab[code] != 0 && !mu && mVol != 0) begin
            hp     = TB_CLK / (2 * freqTab[code]);
            amp    = mVol * 2048;
            e.left = (((mAge / hp) % 2) == 1) ? 16'(amp) : 16'(-amp);
`ifdef BGM_HARMONY_EN
            e.right = (((mAge / (2 * hp)) % 2) == 1) ? 16'(amp) : 16'(-amp);
`else
            e.right = e.left;
`endif
        end
        if (r) begin
            mVol  = 4;
            mIdx  = 0;
            mBeat = 0;
            mAge  = 0;
        end else begin
            if (up && !dn && mVol < 7) mVol++;
            else if (dn && !up && mVol > 0) mVol--;
            if (int'(s) != mPrev) begin
                mIdx  = 0;
                mBeat = 0;
                mAge  = 0;
            end else if (mBeat == BEAT_DIV - 1) begin
                mBeat = 0;
                mIdx  = (mIdx + 1) % TB_LEN;
                mAge  = 0;
            end else begin
                mBeat++;
                mAge = (freqTab[code] == 0) ? 0 : mAge + 1;
            end
        end
        mPrev = int'(s);
        e.vol = 3'(mVol);
        e.idx = 6'(mIdx);
        @(posedge clk);
        sbQ.push_back(e);
        cycle++;
        #1;
    endtask

    task automatic runIdle(input int n);
        repeat (n) applyStimulus(1'b0, curState, 1'b0, 1'b0, curMute);
    endtask

    task automatic checkOutput(input expT e);
        vectors++;
        if (audioL !== e.left) begin
            miscompares++;
            $display("[TB] FAIL left cycle %0d: got %0d expected %0d", cycle, audioL, e.left);
        end
        if (audioR !== e.right) begin
            miscompares++;
            $display("[TB] FAIL right cycle %0d: got %0d expected %0d", cycle, audioR, e.right);
        end
        if (volOut !== e.vol) begin
            miscompares++;
            $display("[TB] FAIL volume cycle %0d: got %0d expected %0d", cycle, volOut, e.vol);
        end
        if (idxOut !== e.idx) begin
            miscompares++;
            $display("[TB] FAIL note_idx cycle %0d: got %0d expected %0d", cycle, idxOut, e.idx);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (sbQ.size() > 0) checkOutput(sbQ.pop_front());
        end
    end

    initial begin
        #2_000_000;
        miscompares++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        loadSongs();
        repeat (3) applyStimulus(1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        runIdle(300);

        repeat (5) begin
            applyStimulus(1'b0, curState, 1'b1, 1'b0, curMute);
            runIdle(7);
        end
        repeat (9) begin
            applyStimulus(1'b0, curState, 1'b0, 1'b1, curMute);
            runIdle(7);
        end
        applyStimulus(1'b0, curState, 1'b1, 1'b1, curMute);
        runIdle(20);
        repeat (3) begin
            applyStimulus(1'b0, curState, 1'b1, 1'b0, curMute);
            runIdle(5);
        end
        applyStimulus(1'b0, curState, 1'b1, 1'b1, curMute);
        runIdle(5);
        applyStimulus(1'b0, curState, 1'b1, 1'b0, curMute);
        runIdle(400);

        curMute = 1'b1;
        runIdle(1500);
        curMute = 1'b0;
        runIdle(500);

        curState = 4'd3;
        runIdle(600);
        curState = 4'd0;
        runIdle(400);

        for (int i = 0; i < 20000; i++) begin
            logic up;
            logic dn;
            logic r;
            up = ($urandom_range(0, 199) == 0);
            dn = ($urandom_range(0, 199) == 0);
            r  = ($urandom_range(0, 7999) == 0);
            if ($urandom_range(0, 499) == 0) curMute = ~curMute;
            if ($urandom_range(0, 2999) == 0) curState = 4'($urandom_range(0, 15));
            applyStimulus(r, curState, up, dn, curMute);
        end

        curState = 4'd0;
        curMute  = 1'b0;
        applyStimulus(1'b1, curState, 1'b0, 1'b0, curMute);
        runIdle(300);
        runIdle(TB_LEN * BEAT_DIV + 200);

        repeat (3) @(negedge clk);
        if (sbQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drain: got %0d pending expected 0", sbQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
